sdram_slot_arbiter: RTL and testbench
=====================================

Name: sdram_slot_arbiter

Overview:
- Shares the single SDRAM controller port between the game loader byte stream and the NES core's CPU/PPU memory ports.
- Loader writes are buffered in a small FIFO and issued one per NES slot, aligned to the `nes_ce` phase. This replaces the ad-hoc `loader_write_triggered` / `loader_write_mem` logic in the top level.
- Sequences the LOAD → DRAIN → RUN handoff and drives the SDRAM data-bus direction and the NES enable.

Parameters:
- ADDR_BITS, 22, width of loader and NES byte addresses.
- FIFO_DEPTH, 4, loader write FIFO entries; power of two, minimum 2.
- SLOT_PHASE, 3, `ce_phase` value on which a loader write is issued or retired.

Ports:
- clk  in  1  system clock (21 MHz NES clock domain).
- resetn  in  1  asynchronous active-low reset.
- ce_phase  in  2  free-running NES clock-enable counter (`nes_ce`).
- load_done  in  1  game loader finished; level signal.
- ld_valid  in  1  loader byte write request.
- ld_ready  out  1  FIFO can accept (not full and state is LOAD).
- ld_addr  in  ADDR_BITS  loader byte address.
- ld_data  in  8  loader byte.
- nes_addr  in  ADDR_BITS  NES memory address.
- nes_rd_cpu  in  1  NES CPU read strobe.
- nes_rd_ppu  in  1  NES PPU read strobe.
- nes_wr  in  1  NES write strobe.
- nes_dout  in  8  NES write data.
- mem_addr  out  ADDR_BITS+3  SDRAM controller address, zero-extended by 3 MSBs.
- mem_we  out  1  SDRAM controller write request.
- mem_din  out  8  SDRAM controller write data.
- mem_oe_a  out  1  CPU read enable to controller.
- mem_oe_b  out  1  PPU read enable to controller.
- sd_drive  out  1  1 = FPGA drives `sdram_d` bus.
- nes_run_en  out  1  NES allowed out of reset; high only in RUN.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- state  out  2  0 = LOAD, 1 = DRAIN, 2 = RUN.

Behaviour:
- Reset (`resetn` = 0, asynchronous):
  - state = LOAD; FIFO empty.
  - `mem_we`, `mem_oe_a`, `mem_oe_b`, `sd_drive`, `nes_run_en`, `ld_ready` = 0.
  - `mem_addr` and `mem_din` = 0; `fifo_level` = 0.
  - `ld_ready` rises on the first clock after reset release.
- FIFO push:
  - Occurs when `ld_valid & ld_ready`; {addr, data} is captured on that edge.
  - Push while full is impossible because `ld_ready` = 0.
  - `ld_valid` while `ld_ready` = 0 is ignored; the loader must hold.
- Issue: on a clk edge with `ce_phase == SLOT_PHASE`, state LOAD or DRAIN:
  - Retire any write in flight: `mem_we` goes to 0, unless a new one issues on the same edge.
  - If the FIFO is non-empty, pop the head into the `mem_addr` / `mem_din` registers and set `mem_we` = 1 and `sd_drive` = 1.
  - `mem_we` is held for exactly 4 clk (one NES slot), giving at most one loader write per slot.
  - Simultaneous push and pop on the same edge: `fifo_level` is unchanged; data ordering is preserved.
  - A push into an empty FIFO on a `SLOT_PHASE` edge is not issued until the next slot (1-slot minimum latency).
- Loader-side outputs: in LOAD and DRAIN, `mem_oe_a` = `mem_oe_b` = 0 and `nes_run_en` = 0.
- State transitions:
  - LOAD → DRAIN on the first edge where `load_done` = 1; `ld_ready` drops on that edge.
  - DRAIN → RUN on a `SLOT_PHASE` edge where the FIFO is empty and no write is being retired on that edge. Its effects appear after that edge:
    - `mem_we` = 0; `sd_drive` = 0.
    - `nes_run_en` = 1.
  - RUN → LOAD on the first edge where `load_done` = 0 (reload):
    - `nes_run_en`, `mem_we`, `mem_oe_a`, `mem_oe_b` and `sd_drive` go to 0 on that edge.
    - The FIFO is already empty; `ld_ready` = 1 next cycle.
- RUN (combinational pass-through, zero added latency):
  - `mem_addr` = {3'b0, `nes_addr`}; `mem_we` = `nes_wr`; `mem_din` = `nes_dout`.
  - `mem_oe_a` = `nes_rd_cpu`; `mem_oe_b` = `nes_rd_ppu`; `sd_drive` = `nes_wr`.
- `load_done` dropping during DRAIN: go to LOAD, keep the FIFO contents, resume issuing.
- `ce_phase` wraps 3 → 0 freely; slot detection is equality only.

Test Plan:
- Reset mid-write: assert `resetn` = 0 while `mem_we` = 1 → `mem_we` = 0, `fifo_level` = 0, state = 0 immediately (asynchronous).
- Burst push: 6 back-to-back `ld_valid` with FIFO_DEPTH = 4 → `ld_ready` low after 4 accepts; writes appear on `mem_we` in order at 0x000000, 0x000001, …, each high for 4 clk and spaced by 4 clk.
- Single write timing: push {0x000010, 0xA5} at `ce_phase` = 1 → `mem_we` rises on the next `ce_phase` = 3 edge with `mem_addr` = 0x0000010 and `mem_din` = 0xA5, and falls 4 clk later.
- Drain handoff: 3 entries queued, then `load_done` = 1 → state = 1 until the third write retires; `nes_run_en` = 1 on the following slot edge, never earlier; no loader write is lost.
- RUN pass-through: `nes_addr` = 0x12345, `nes_rd_ppu` = 1 → same cycle `mem_addr` = 0x0012345, `mem_oe_b` = 1, `sd_drive` = 0; with `nes_wr` = 1 → `sd_drive` = 1 and `mem_we` = 1.
- Reload: in RUN, drop `load_done` → `nes_run_en` = 0 on that edge, state = 0, `ld_ready` = 1 the next cycle; a new byte stream loads correctly.

Source files
------------

// File: rtl/sdram_slot_arbiter_if.sv
// Bus bundle between the SDRAM slot arbiter and its surroundings: the loader
// byte stream, the NES memory ports, the SDRAM controller port and status.
interface sdram_slot_arbiter_if #(
    parameter int ADDR_BITS  = 22,
    parameter int FIFO_DEPTH = 4
);
    logic [1:0]                     ce_phase;
    logic                           load_done;
    logic                           ld_valid;
    logic                           ld_ready;
    logic [ADDR_BITS-1:0]           ld_addr;
    logic [7:0]                     ld_data;
    logic [ADDR_BITS-1:0]           nes_addr;
    logic                           nes_rd_cpu;
    logic                           nes_rd_ppu;
    logic                           nes_wr;
    logic [7:0]                     nes_dout;
    logic [ADDR_BITS+2:0]           mem_addr;
    logic                           mem_we;
    logic [7:0]                     mem_din;
    logic                           mem_oe_a;
    logic                           mem_oe_b;
    logic                           sd_drive;
    logic                           nes_run_en;
    logic [$clog2(FIFO_DEPTH):0]    fifo_level;
    logic [1:0]                     state;

    modport slave (
        input  ce_phase, load_done, ld_valid, ld_addr, ld_data,
               nes_addr, nes_rd_cpu, nes_rd_ppu, nes_wr, nes_dout,
        output ld_ready, mem_addr, mem_we, mem_din, mem_oe_a, mem_oe_b,
               sd_drive, nes_run_en, fifo_level, state
    );

    modport master (
        output ce_phase, load_done, ld_valid, ld_addr, ld_data,
               nes_addr, nes_rd_cpu, nes_rd_ppu, nes_wr, nes_dout,
        input  ld_ready, mem_addr, mem_we, mem_din, mem_oe_a, mem_oe_b,
               sd_drive, nes_run_en, fifo_level, state
    );
endinterface

// File: rtl/sdram_slot_arbiter.sv
// SDRAM slot arbiter: buffers loader byte writes in a small FIFO and issues
// one per NES slot while loading, then hands the SDRAM port to the NES core
// (combinational pass-through) once every buffered write has retired.
module sdram_slot_arbiter #(
    parameter int ADDR_BITS  = 22,
    parameter int FIFO_DEPTH = 4,
    parameter int SLOT_PHASE = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    sdram_slot_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_BITS-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [7:0]             r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   r_ld_ready;

    logic [ADDR_BITS-1:0]   r_mem_addr;
    logic [7:0]             r_mem_din;
    logic                   r_mem_we;

    logic                   w_slot;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    // A write slot is the single ce_phase value on which writes issue/retire.
    assign w_slot  = (bus.ce_phase == 2'(SLOT_PHASE));
    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = bus.ld_valid & r_ld_ready;
    assign w_pop   = w_slot & ~w_empty & (r_state != ST_RUN);

    // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next-state logic for the LOAD -> DRAIN -> RUN handoff.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (bus.load_done) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                // Hand over only once the last write has also been retired.
                if (!bus.load_done) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_slot && w_empty && !r_mem_we) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (!bus.load_done) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.ld_addr;
            r_fifo_data[r_wr_ptr] <= bus.ld_data;
        end
    end

    // FIFO pointers, occupancy, loader handshake and the issued-write registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_ld_ready <= 1'b0;
            r_mem_addr <= {ADDR_BITS{1'b0}};
            r_mem_din  <= 8'h00;
            r_mem_we   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_ld_ready <= (w_state_nxt == ST_LOAD) &&
                          (w_count_nxt != CNT_W'(FIFO_DEPTH));
            // A write stays on the bus for one whole slot (slot edge to slot edge).
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_mem_addr <= r_fifo_addr[r_rd_ptr];
                r_mem_din  <= r_fifo_data[r_rd_ptr];
                r_mem_we   <= 1'b1;
            end else if (w_slot || (r_state == ST_RUN)) begin
                r_mem_we   <= 1'b0;
            end
        end
    end

    // SDRAM port mux: NES signals pass straight through in RUN, loader writes otherwise.
    always_comb begin
        bus.mem_addr = {3'b000, r_mem_addr};
        bus.mem_we   = r_mem_we;
        bus.mem_din  = r_mem_din;
        bus.mem_oe_a = 1'b0;
        bus.mem_oe_b = 1'b0;
        bus.sd_drive = r_mem_we;
        if (r_state == ST_RUN) begin
            bus.mem_addr = {3'b000, bus.nes_addr};
            bus.mem_we   = bus.nes_wr;
            bus.mem_din  = bus.nes_dout;
            bus.mem_oe_a = bus.nes_rd_cpu;
            bus.mem_oe_b = bus.nes_rd_ppu;
            bus.sd_drive = bus.nes_wr;
        end else begin
            bus.mem_oe_a = 1'b0;
            bus.mem_oe_b = 1'b0;
        end
    end

    assign bus.ld_ready   = r_ld_ready;
    assign bus.nes_run_en = (r_state == ST_RUN);
    assign bus.fifo_level = r_count;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter: reset, single write timing, burst
// push with FIFO full, drain handoff, RUN pass-through, reload, reset mid-write.
module tb_sdram_slot_arbiter;
    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    sdram_slot_arbiter_if bus ();

    sdram_slot_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; ce_phase advances right after it, like the NES enable counter.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.ce_phase = bus.ce_phase + 2'd1;
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int i = 0; i < 4; i++) begin
            if (bus.ce_phase != p) tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int sched [10] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 5};

        resetn         = 1'b0;
        bus.ce_phase   = 2'd0;
        bus.load_done  = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_addr    = 22'h0;
        bus.ld_data    = 8'h00;
        bus.nes_addr   = 22'h0;
        bus.nes_rd_cpu = 1'b0;
        bus.nes_rd_ppu = 1'b0;
        bus.nes_wr     = 1'b0;
        bus.nes_dout   = 8'h00;

        // ---- reset state ----
        tick();
        tick();
        check("rst_state",    32'(bus.state),      32'd0);
        check("rst_ld_ready", 32'(bus.ld_ready),   32'd0);
        check("rst_mem_we",   32'(bus.mem_we),     32'd0);
        check("rst_sd_drive", 32'(bus.sd_drive),   32'd0);
        check("rst_run_en",   32'(bus.nes_run_en), 32'd0);
        check("rst_level",    32'(bus.fifo_level), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr),   32'd0);
        check("rst_mem_din",  32'(bus.mem_din),    32'd0);
        resetn = 1'b1;
        #1;
        check("rel_ld_ready0", 32'(bus.ld_ready), 32'd0);
        tick();
        check("rel_ld_ready1", 32'(bus.ld_ready), 32'd1);

        // ---- single write timing: push at phase 1, issue on next phase-3 edge ----
        wait_phase(2'd1);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 22'h000010;
        bus.ld_data  = 8'hA5;
        tick();
        bus.ld_valid = 1'b0;
        check("sw_level1", 32'(bus.fifo_level), 32'd1);
        check("sw_we_p1",  32'(bus.mem_we),     32'd0);
        tick();
        check("sw_we_p2",  32'(bus.mem_we),     32'd0);
        tick();
        check("sw_we_rise", 32'(bus.mem_we),    32'd1);
        check("sw_addr",    32'(bus.mem_addr),  32'h0000010);
        check("sw_din",     32'(bus.mem_din),   32'hA5);
        check("sw_drive",   32'(bus.sd_drive),  32'd1);
        check("sw_level0",  32'(bus.fifo_level), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sw_we_hold", 32'(bus.mem_we), 32'd1);
        end
        tick();
        check("sw_we_fall", 32'(bus.mem_we),   32'd0);
        check("sw_drive0",  32'(bus.sd_drive), 32'd0);

        // ---- burst push: 6 bytes held valid from a phase-3 edge ----
        wait_phase(2'd3);
        bus.ld_valid = 1'b1;
        for (int e = 0; e < 10; e++) begin
            bus.ld_addr = 22'(sched[e]);
            bus.ld_data = 8'h30 + 8'(sched[e]);
            tick();
            if (e == 3) begin
                check("bp_full_ready", 32'(bus.ld_ready),   32'd0);
                check("bp_full_level", 32'(bus.fifo_level), 32'd4);
                check("bp_no_we_yet",  32'(bus.mem_we),     32'd0);
            end
            if (e == 4) begin
                check("bp_w0_we",    32'(bus.mem_we),     32'd1);
                check("bp_w0_addr",  32'(bus.mem_addr),   32'd0);
                check("bp_w0_din",   32'(bus.mem_din),    32'h30);
                check("bp_w0_level", 32'(bus.fifo_level), 32'd3);
                check("bp_w0_ready", 32'(bus.ld_ready),   32'd1);
            end
        end
        bus.ld_valid = 1'b0;
        check("bp_last_level", 32'(bus.fifo_level), 32'd4);
        check("bp_last_ready", 32'(bus.ld_ready),   32'd0);
        check("bp_w1_addr",    32'(bus.mem_addr),   32'd1);
        check("bp_w1_we",      32'(bus.mem_we),     32'd1);
        tick();
        tick();
        for (int k = 2; k < 6; k++) begin
            tick();
            check("bp_wk_addr", 32'(bus.mem_addr), 32'(k));
            check("bp_wk_din",  32'(bus.mem_din),  32'h30 + 32'(k));
            check("bp_wk_we",   32'(bus.mem_we),   32'd1);
            for (int i = 0; i < 3; i++) begin
                tick();
                check("bp_wk_hold", 32'(bus.mem_we), 32'd1);
            end
        end
        tick();
        check("bp_done_we",    32'(bus.mem_we),     32'd0);
        check("bp_done_level", 32'(bus.fifo_level), 32'd0);

        // ---- drain handoff: 3 entries queued, then load_done ----
        wait_phase(2'd0);
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ld_addr = 22'h000100 + 22'(i);
            bus.ld_data = 8'h50 + 8'(i);
            tick();
        end
        bus.ld_valid  = 1'b0;
        bus.load_done = 1'b1;
        tick();
        check("dr_state",  32'(bus.state),      32'd1);
        check("dr_ready",  32'(bus.ld_ready),   32'd0);
        check("dr_b0_we",  32'(bus.mem_we),     32'd1);
        check("dr_b0_addr", 32'(bus.mem_addr),  32'h100);
        check("dr_level",  32'(bus.fifo_level), 32'd2);
        check("dr_run0",   32'(bus.nes_run_en), 32'd0);
        for (int j = 1; j < 3; j++) begin
            tick();
            tick();
            tick();
            check("dr_hold_state", 32'(bus.state),  32'd1);
            check("dr_hold_we",    32'(bus.mem_we), 32'd1);
            tick();
            check("dr_bj_addr", 32'(bus.mem_addr), 32'h100 + 32'(j));
            check("dr_bj_din",  32'(bus.mem_din),  32'h50 + 32'(j));
        end
        check("dr_empty", 32'(bus.fifo_level), 32'd0);
        tick();
        tick();
        tick();
        tick();
        check("dr_retire_we",    32'(bus.mem_we),     32'd0);
        check("dr_retire_state", 32'(bus.state),      32'd1);
        check("dr_retire_run",   32'(bus.nes_run_en), 32'd0);
        tick();
        tick();
        tick();
        check("dr_early_run", 32'(bus.nes_run_en), 32'd0);
        tick();
        check("dr_run_state", 32'(bus.state),      32'd2);
        check("dr_run_en",    32'(bus.nes_run_en), 32'd1);
        check("dr_run_drive", 32'(bus.sd_drive),   32'd0);

        // ---- RUN pass-through ----
        bus.nes_addr   = 22'h012345;
        bus.nes_rd_ppu = 1'b1;
        #1;
        check("run_addr",  32'(bus.mem_addr), 32'h0012345);
        check("run_oe_b",  32'(bus.mem_oe_b), 32'd1);
        check("run_oe_a",  32'(bus.mem_oe_a), 32'd0);
        check("run_drv0",  32'(bus.sd_drive), 32'd0);
        check("run_we0",   32'(bus.mem_we),   32'd0);
        bus.nes_wr   = 1'b1;
        bus.nes_dout = 8'h3C;
        bus.nes_rd_cpu = 1'b1;
        #1;
        check("run_drv1", 32'(bus.sd_drive), 32'd1);
        check("run_we1",  32'(bus.mem_we),   32'd1);
        check("run_din",  32'(bus.mem_din),  32'h3C);
        check("run_oe_a1", 32'(bus.mem_oe_a), 32'd1);
        wait_phase(2'd3);
        tick();
        check("run_stays", 32'(bus.state), 32'd2);

        // ---- reload: drop load_done while the NES still strobes ----
        bus.load_done = 1'b0;
        tick();
        check("rl_state",  32'(bus.state),      32'd0);
        check("rl_run_en", 32'(bus.nes_run_en), 32'd0);
        check("rl_we",     32'(bus.mem_we),     32'd0);
        check("rl_oe_a",   32'(bus.mem_oe_a),   32'd0);
        check("rl_oe_b",   32'(bus.mem_oe_b),   32'd0);
        check("rl_drive",  32'(bus.sd_drive),   32'd0);
        check("rl_ready",  32'(bus.ld_ready),   32'd1);
        bus.nes_wr     = 1'b0;
        bus.nes_rd_cpu = 1'b0;
        bus.nes_rd_ppu = 1'b0;
        bus.ld_valid   = 1'b1;
        bus.ld_addr    = 22'h000200;
        bus.ld_data    = 8'h77;
        tick();
        bus.ld_addr    = 22'h000201;
        bus.ld_data    = 8'h78;
        tick();
        bus.ld_valid   = 1'b0;
        check("rl_level2", 32'(bus.fifo_level), 32'd2);
        wait_phase(2'd3);
        tick();
        check("rl_c0_we",    32'(bus.mem_we),     32'd1);
        check("rl_c0_addr",  32'(bus.mem_addr),   32'h200);
        check("rl_c0_din",   32'(bus.mem_din),    32'h77);
        check("rl_c0_level", 32'(bus.fifo_level), 32'd1);

        // ---- asynchronous reset in the middle of a write ----
        #2;
        resetn = 1'b0;
        #1;
        check("mr_we",    32'(bus.mem_we),     32'd0);
        check("mr_level", 32'(bus.fifo_level), 32'd0);
        check("mr_state", 32'(bus.state),      32'd0);
        check("mr_ready", 32'(bus.ld_ready),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
